// File: rtl/poly_voice_pkg.sv
// Shared types and constant helpers for the polyphonic wavetable voice engine.
package poly_voice_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_NORM
  } state_t;

  function automatic int mid_of(input int sample_width);
    return 1 << (sample_width - 1);
  endfunction

  function automatic int acc_width(input int sample_width, input int num_voices);
    return sample_width + 1 + $clog2(num_voices);
  endfunction

  // ceil(log2(active)), 0 for 0 or 1 active voices; active is at most 16
  function automatic int norm_shift(input int active);
    int s;
    s = 0;
    for (int i = 0; i < 5; i++) begin
      if ((1 << s) < active) s = s + 1;
    end
    return s;
  endfunction

endpackage

// File: rtl/voice_phase_bank.sv
// Per-voice phase accumulators, read and updated one voice per SCAN cycle.
// POLY_VOICE_RETRIGGER_EN: a gate rising edge between frames restarts that voice at phase 0.
module voice_phase_bank #(
  parameter int NUM_VOICES  = 8,
  parameter int PHASE_WIDTH = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int IDX_W       = 3
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              start,
  input  logic [NUM_VOICES-1:0]             gate,
  input  logic                              scan_en,
  input  logic [IDX_W-1:0]                  idx,
  input  logic                              gated,
  input  logic [NUM_VOICES*PHASE_WIDTH-1:0] inc,
  output logic [ADDR_WIDTH-1:0]             addr
);

  logic [PHASE_WIDTH-1:0] phase_q [NUM_VOICES];
  logic [PHASE_WIDTH-1:0] phase_cur;
  logic [PHASE_WIDTH-1:0] inc_sel;

  assign inc_sel = inc[idx*PHASE_WIDTH +: PHASE_WIDTH];

`ifdef POLY_VOICE_RETRIGGER_EN
  logic [NUM_VOICES-1:0] gate_hist_q;
  logic [NUM_VOICES-1:0] retrig_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      gate_hist_q <= '0;
      retrig_q    <= '0;
    end else if (start) begin
      retrig_q    <= gate & ~gate_hist_q;
      gate_hist_q <= gate;
    end
  end

  // The zeroed phase is what gets read and advanced, so the note starts at table entry 0
  assign phase_cur = retrig_q[idx] ? '0 : phase_q[idx];
`else
  logic unused_retrig;
  assign unused_retrig = ^{start, gate};
  assign phase_cur     = phase_q[idx];
`endif

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int v = 0; v < NUM_VOICES; v++) phase_q[v] <= '0;
    end else if (scan_en && gated) begin
      phase_q[idx] <= phase_cur + inc_sel;
    end
  end

  assign addr = phase_cur[PHASE_WIDTH-1 -: ADDR_WIDTH];

endmodule

// File: rtl/poly_voice_engine.sv
// Polyphonic wavetable mixer: scans every voice once per sample tick and outputs the normalised mix.
// Optional POLY_VOICE_RETRIGGER_EN restarts a voice's phase on a gate rising edge.
//
// state    | meaning
// ST_IDLE  | waiting for sample_tick_in
// ST_SCAN  | one voice per cycle: issue table read, advance phase
// ST_DRAIN | two cycles collecting the last table reads
// ST_NORM  | scale, saturate and publish the mixed sample
module poly_voice_engine
  import poly_voice_pkg::*;
#(
  parameter int NUM_VOICES   = 8,
  parameter int PHASE_WIDTH  = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int SAMPLE_WIDTH = 8
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                sample_tick_in,
  input  logic [NUM_VOICES-1:0]               gate_in,
  input  logic [NUM_VOICES*PHASE_WIDTH-1:0]   inc_in,
  output logic [ADDR_WIDTH-1:0]               addr_out,
  input  logic [SAMPLE_WIDTH-1:0]             data_in,
  output logic [SAMPLE_WIDTH-1:0]             sample_out,
  output logic                                sample_valid_out,
  output logic [$clog2(NUM_VOICES+1)-1:0]     active_count_out,
  output logic                                overrun_out
);

  localparam int MID   = mid_of(SAMPLE_WIDTH);
  localparam int ACC_W = acc_width(SAMPLE_WIDTH, NUM_VOICES);
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int CNT_W = $clog2(NUM_VOICES + 1);
  localparam int SMAX  = (1 << SAMPLE_WIDTH) - 1;

  state_t                   state_q;
  logic [IDX_W-1:0]         idx_q;
  logic                     drain_q;
  logic [NUM_VOICES-1:0]    frame_gate_q;
  logic                     tag0_q;
  logic                     tag1_q;
  logic signed [ACC_W-1:0]  acc_q;

  logic                     start;
  logic [ADDR_WIDTH-1:0]    bank_addr;
  logic [CNT_W-1:0]         gate_cnt;
  logic signed [ACC_W-1:0]  acc_shr;
  logic signed [ACC_W:0]    norm_sum;
  logic [SAMPLE_WIDTH-1:0]  norm_sample;

  assign start = sample_tick_in && (state_q == ST_IDLE);

  voice_phase_bank #(
    .NUM_VOICES  (NUM_VOICES),
    .PHASE_WIDTH (PHASE_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .IDX_W       (IDX_W)
  ) u_bank (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .start   (start),
    .gate    (gate_in),
    .scan_en (state_q == ST_SCAN),
    .idx     (idx_q),
    .gated   (frame_gate_q[idx_q]),
    .inc     (inc_in),
    .addr    (bank_addr)
  );

  assign addr_out = (state_q == ST_SCAN) ? bank_addr : '0;

  always_comb begin
    gate_cnt = '0;
    for (int v = 0; v < NUM_VOICES; v++) gate_cnt = gate_cnt + CNT_W'(frame_gate_q[v]);
    acc_shr  = acc_q >>> norm_shift(int'(gate_cnt));
    norm_sum = {acc_shr[ACC_W-1], acc_shr} + (ACC_W+1)'(MID);
    if (norm_sum[ACC_W])
      norm_sample = '0;
    else if (norm_sum[ACC_W-1:0] > ACC_W'(SMAX))
      norm_sample = SAMPLE_WIDTH'(SMAX);
    else
      norm_sample = norm_sum[SAMPLE_WIDTH-1:0];
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q          <= ST_IDLE;
      idx_q            <= '0;
      drain_q          <= 1'b0;
      frame_gate_q     <= '0;
      tag0_q           <= 1'b0;
      tag1_q           <= 1'b0;
      acc_q            <= '0;
      sample_out       <= SAMPLE_WIDTH'(MID);
      sample_valid_out <= 1'b0;
      active_count_out <= '0;
      overrun_out      <= 1'b0;
    end else begin
      sample_valid_out <= 1'b0;
      overrun_out      <= sample_tick_in && (state_q != ST_IDLE);
      // Read data returns two cycles after the address; the tag follows it down the same pipe
      tag0_q <= (state_q == ST_SCAN) && frame_gate_q[idx_q];
      tag1_q <= tag0_q;
      if (tag1_q) acc_q <= acc_q + ACC_W'(data_in) - ACC_W'(MID);

      case (state_q)
        ST_IDLE: begin
          if (sample_tick_in) begin
            state_q      <= ST_SCAN;
            idx_q        <= '0;
            frame_gate_q <= gate_in;
            acc_q        <= '0;
          end
        end
        ST_SCAN: begin
          if (idx_q == IDX_W'(NUM_VOICES - 1)) begin
            state_q <= ST_DRAIN;
            drain_q <= 1'b0;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        ST_DRAIN: begin
          drain_q <= 1'b1;
          if (drain_q) state_q <= ST_NORM;
        end
        ST_NORM: begin
          sample_out       <= norm_sample;
          active_count_out <= gate_cnt;
          sample_valid_out <= 1'b1;
          state_q          <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_voice_engine.sv
// Bench for poly_voice_engine: directed and random frames checked against a frame-level model.
module tb_poly_voice_engine;

  localparam int N = 8;

  logic            clk_in = 1'b0;
  logic            rst_in;
  logic            sample_tick_in;
  logic [N-1:0]    gate_in;
  logic [N*32-1:0] inc_in;
  logic [7:0]      addr_out;
  logic [7:0]      data_in;
  logic [7:0]      sample_out;
  logic            sample_valid_out;
  logic [3:0]      active_count_out;
  logic            overrun_out;

  always #5 clk_in = ~clk_in;

  poly_voice_engine dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .sample_tick_in   (sample_tick_in),
    .gate_in          (gate_in),
    .inc_in           (inc_in),
    .addr_out         (addr_out),
    .data_in          (data_in),
    .sample_out       (sample_out),
    .sample_valid_out (sample_valid_out),
    .active_count_out (active_count_out),
    .overrun_out      (overrun_out)
  );

  // Wavetable ROM with two cycles of read latency
  logic [7:0] rom [256];
  logic [7:0] rd1, rd2;
  always @(posedge clk_in) begin
    rd1 <= addr_out;
    rd2 <= rom[rd1];
  end
  assign data_in = rd2;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_phase [N];
  logic [31:0] incs    [N];
`ifdef POLY_VOICE_RETRIGGER_EN
  logic [N-1:0] m_hist;
`endif
  logic [7:0]  e_addr [N];
  int          e_sample;
  int          e_active;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic model_reset();
    for (int v = 0; v < N; v++) m_phase[v] = '0;
`ifdef POLY_VOICE_RETRIGGER_EN
    m_hist = '0;
`endif
  endtask

  task automatic model_frame(input logic [N-1:0] g);
    int acc;
    int s;
    int act;
    logic [31:0] p;
    acc = 0;
    act = 0;
    s   = 0;
    for (int v = 0; v < N; v++) begin
      p = m_phase[v];
`ifdef POLY_VOICE_RETRIGGER_EN
      if (g[v] && !m_hist[v]) p = '0;
`endif
      e_addr[v] = p[31:24];
      if (g[v]) begin
        acc = acc + int'(rom[p[31:24]]) - 128;
        act++;
        m_phase[v] = p + incs[v];
      end
    end
`ifdef POLY_VOICE_RETRIGGER_EN
    m_hist = g;
`endif
    while ((1 << s) < act) s++;
    e_sample = 128 + (acc >>> s);
    if (e_sample < 0) e_sample = 0;
    if (e_sample > 255) e_sample = 255;
    e_active = act;
  endtask

  // Runs one frame: tick now, optional extra tick at step extra_at, observe for len steps
  task automatic run_frame(input logic [N-1:0] g, input int extra_at, input int len);
    int nv;
    int vk;
    int no;
    nv = 0;
    vk = -1;
    no = 0;
    model_frame(g);
    gate_in = g;
    for (int v = 0; v < N; v++) inc_in[v*32 +: 32] = incs[v];
    sample_tick_in = 1'b1;
    for (int k = 1; k <= len; k++) begin
      step();
      if (k == 1) gate_in = N'($urandom);
      if (k == 1 || k == extra_at + 1) sample_tick_in = 1'b0;
      if (k == extra_at) sample_tick_in = 1'b1;
      if (k <= N) check($sformatf("addr_v%0d", k - 1), 64'(addr_out), 64'(e_addr[k-1]));
      if (k == N + 1) check("addr_after_scan", 64'(addr_out), 64'd0);
      if (sample_valid_out) begin
        nv++;
        vk = k;
      end
      if (overrun_out) no++;
    end
    check("valid_count", 64'(nv), 64'd1);
    check("valid_latency", 64'(vk), 64'(N + 4));
    check("sample", 64'(sample_out), 64'(e_sample));
    check("active", 64'(active_count_out), 64'(e_active));
    check("overrun_count", 64'(no), (extra_at > 0) ? 64'd1 : 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      rom[i] = 8'($rtoi(128.0 + 127.0 * $sin(6.283185307179586 * real'(i) / 256.0) + 0.5));
    for (int v = 0; v < N; v++) incs[v] = '0;
    model_reset();
    rst_in         = 1'b0;
    sample_tick_in = 1'b0;
    gate_in        = '0;
    inc_in         = '0;
    step(); step(); step();
    check("rst_sample", 64'(sample_out), 64'd128);
    check("rst_valid", 64'(sample_valid_out), 64'd0);
    check("rst_active", 64'(active_count_out), 64'd0);
    check("rst_overrun", 64'(overrun_out), 64'd0);
    check("rst_addr", 64'(addr_out), 64'd0);
    rst_in = 1'b1;
    step();

    // Single voice stepping through the sine table
    incs[0] = 32'h0100_0000;
    for (int f = 0; f < 6; f++) run_frame(8'h01, -1, N + 8);

    // No voices gated, then confirm phases held
    run_frame(8'h00, -1, N + 8);
    run_frame(8'h01, -1, N + 8);

    // Tick landing on the valid cycle starts the next frame cleanly
    run_frame(8'h01, -1, N + 4);
    run_frame(8'h01, -1, N + 8);

    // Tick while busy
    for (int v = 0; v < N; v++) incs[v] = $urandom;
    run_frame(8'h0F, 5, N + 8);

    // Random gates and increments
    for (int f = 0; f < 10; f++) begin
      for (int v = 0; v < N; v++) incs[v] = $urandom;
      run_frame(N'($urandom), -1, N + 8);
    end

    // Reset in the middle of a scan
    gate_in = 8'hFF;
    sample_tick_in = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      sample_tick_in = 1'b0;
    end
    rst_in = 1'b0;
    step();
    check("midrst_addr", 64'(addr_out), 64'd0);
    check("midrst_sample", 64'(sample_out), 64'd128);
    step();
    rst_in = 1'b1;
    model_reset();
    begin
      int nv;
      nv = 0;
      for (int k = 0; k < 20; k++) begin
        step();
        if (sample_valid_out) nv++;
      end
      check("midrst_no_valid", 64'(nv), 64'd0);
    end
    check("midrst_sample_after", 64'(sample_out), 64'd128);
    check("midrst_active", 64'(active_count_out), 64'd0);

    // Phase wraparound from zero
    for (int v = 0; v < N; v++) incs[v] = '0;
    incs[0] = 32'hFFFF_FFFF;
    run_frame(8'h01, -1, N + 8);
    check("wrap_phase1", 64'(dut.u_bank.phase_q[0]), 64'hFFFF_FFFF);
    run_frame(8'h01, -1, N + 8);
    check("wrap_phase2", 64'(dut.u_bank.phase_q[0]), 64'hFFFF_FFFE);

    // Constant tables with two voices: positive and negative saturation edges
    for (int i = 0; i < 256; i++) rom[i] = 8'd255;
    run_frame(8'h03, -1, N + 8);
    for (int i = 0; i < 256; i++) rom[i] = 8'd1;
    run_frame(8'h03, -1, N + 8);
    for (int i = 0; i < 256; i++) rom[i] = 8'd0;
    run_frame(8'h03, -1, N + 8);

    // Voice 2 gated off and back on
    for (int i = 0; i < 256; i++)
      rom[i] = 8'($rtoi(128.0 + 127.0 * $sin(6.283185307179586 * real'(i) / 256.0) + 0.5));
    incs[2] = 32'h2345_6789;
    run_frame(8'h04, -1, N + 8);
    run_frame(8'h04, -1, N + 8);
    run_frame(8'h00, -1, N + 8);
    run_frame(8'h04, -1, N + 8);
    run_frame(8'h05, -1, N + 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
